// File: rtl/exu_branch_jump_swc.sv
`default_nettype none
// ============================================================================
// Module      : exu_branch_jump_swc
// Description : Branch/jump execution unit. Executes JAL, JALR and the six
//               RV32I conditional branches under an internal IDLE/RD/EX/WB
//               sequencer with a start/done handshake. It reads rs1/rs2
//               through two register-file read ports, writes the link
//               register, redirects the PC and flushes the front end.
// Options     : EXU_BRANCH_MISALIGN_TRAP_EN - when defined, a taken target
//               with target[1:0] != 0 suppresses pc_write/flush/reg_wen and
//               raises misalign with done. When undefined, misalign is tied
//               low and the redirect uses the computed target unchanged.
// Ports       : hclk/hrstn        clock, asynchronous active-low reset
//               start, dec_*      launch request and decoded instruction
//                                 fields (latched on accept)
//               pc                PC of the instruction
//               reg_raddr/ren_*   register-file read request (RD state)
//               reg_rdata_*       read data, valid the cycle after ren
//               reg_waddr/wen/wdata  link-register write (WB state)
//               pc_write/pc_wdata PC redirect (WB state)
//               flush             front-end flush (WB state)
//               busy/done/taken/misalign  status; all outputs registered
// Revision    : 1.0 - initial release
// ============================================================================
module exu_branch_jump_swc #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int FLUSH_W  = 2,
  parameter int LINK_INC = 4
) (
  input  logic              hclk,
  input  logic              hrstn,
  input  logic              start,
  input  logic              dec_jal,
  input  logic              dec_jalr,
  input  logic              dec_branch,
  input  logic [2:0]        dec_funct3,
  input  logic [11:0]       dec_imm_type_i,
  input  logic [20:0]       dec_imm_type_j,
  input  logic [12:0]       dec_imm_type_b,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [XLEN-1:0]   pc,
  output logic [REG_AW-1:0] reg_raddr_1,
  output logic [REG_AW-1:0] reg_raddr_2,
  output logic              reg_ren_1,
  output logic              reg_ren_2,
  input  logic [XLEN-1:0]   reg_rdata_1,
  input  logic [XLEN-1:0]   reg_rdata_2,
  output logic [REG_AW-1:0] reg_waddr,
  output logic              reg_wen,
  output logic [XLEN-1:0]   reg_wdata,
  output logic              pc_write,
  output logic [XLEN-1:0]   pc_wdata,
  output logic [FLUSH_W-1:0] flush,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic              misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_JAL  = 2'd1,
    OP_JALR = 2'd2,
    OP_BR   = 2'd3
  } op_t;

  // Latched instruction context
  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   off_q, off_d;     // sign-extended offset of the selected op
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  // Registered outputs
  logic [REG_AW-1:0]  reg_raddr_1_q, reg_raddr_1_d;
  logic [REG_AW-1:0]  reg_raddr_2_q, reg_raddr_2_d;
  logic               reg_ren_1_q, reg_ren_1_d;
  logic               reg_ren_2_q, reg_ren_2_d;
  logic [REG_AW-1:0]  reg_waddr_q, reg_waddr_d;
  logic               reg_wen_q, reg_wen_d;
  logic [XLEN-1:0]    reg_wdata_q, reg_wdata_d;
  logic               pc_write_q, pc_write_d;
  logic [XLEN-1:0]    pc_wdata_q, pc_wdata_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               taken_q, taken_d;
  logic               misalign_d;

  // Offset sign extension
  logic [XLEN-1:0] sext_i, sext_j, sext_b;
  assign sext_i = {{(XLEN-12){dec_imm_type_i[11]}}, dec_imm_type_i};
  assign sext_j = {{(XLEN-21){dec_imm_type_j[20]}}, dec_imm_type_j};
  assign sext_b = {{(XLEN-13){dec_imm_type_b[12]}}, dec_imm_type_b};

  // EX-stage evaluation; operands come straight from the read ports, which
  // return data in the cycle after the RD-state read request.
  logic [XLEN-1:0] link, jalr_sum, target;
  logic            cond, is_jump, is_taken, trap, commit;

  always_comb begin
    link     = pc_q + XLEN'(LINK_INC);
    jalr_sum = reg_rdata_1 + off_q;
    is_jump  = (op_q == OP_JAL) || (op_q == OP_JALR);

    unique case (funct3_q)
      3'b000:  cond = (reg_rdata_1 == reg_rdata_2);
      3'b001:  cond = (reg_rdata_1 != reg_rdata_2);
      3'b100:  cond = ($signed(reg_rdata_1) <  $signed(reg_rdata_2));
      3'b101:  cond = ($signed(reg_rdata_1) >= $signed(reg_rdata_2));
      3'b110:  cond = (reg_rdata_1 <  reg_rdata_2);
      3'b111:  cond = (reg_rdata_1 >= reg_rdata_2);
      default: cond = 1'b0;  // 010/011 never branch
    endcase

    case (op_q)
      OP_JAL:  begin target = pc_q + off_q;                                is_taken = 1'b1; end
      OP_JALR: begin target = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};          is_taken = 1'b1; end
      OP_BR:   begin target = pc_q + off_q;                                is_taken = cond; end
      default: begin target = '0;                                          is_taken = 1'b0; end
    endcase

`ifdef EXU_BRANCH_MISALIGN_TRAP_EN
    trap = is_taken && (target[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
    commit = is_taken && !trap;
  end

  // Next-state / next-output logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    pc_d     = pc_q;
    rd_d     = rd_q;

    // Strobes and data outputs are zero unless the destination state drives them
    reg_raddr_1_d = '0;
    reg_raddr_2_d = '0;
    reg_ren_1_d   = 1'b0;
    reg_ren_2_d   = 1'b0;
    reg_waddr_d   = '0;
    reg_wen_d     = 1'b0;
    reg_wdata_d   = '0;
    pc_write_d    = 1'b0;
    pc_wdata_d    = '0;
    flush_d       = '0;
    done_d        = 1'b0;
    taken_d       = 1'b0;
    misalign_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          funct3_d = dec_funct3;
          pc_d     = pc;
          rd_d     = dec_rd;
          if (dec_jal) begin
            op_d    = OP_JAL;
            off_d   = sext_j;
            state_d = S_EX;
          end else if (dec_jalr) begin
            op_d          = OP_JALR;
            off_d         = sext_i;
            state_d       = S_RD;
            reg_ren_1_d   = 1'b1;
            reg_raddr_1_d = dec_rs1;
          end else if (dec_branch) begin
            op_d          = OP_BR;
            off_d         = sext_b;
            state_d       = S_RD;
            reg_ren_1_d   = 1'b1;
            reg_raddr_1_d = dec_rs1;
            reg_ren_2_d   = 1'b1;
            reg_raddr_2_d = dec_rs2;
          end else begin
            // No op selected: complete without any side effects
            op_d    = OP_NONE;
            off_d   = '0;
            state_d = S_WB;
            done_d  = 1'b1;
          end
        end
      end

      S_RD: begin
        state_d = S_EX;
      end

      S_EX: begin
        state_d    = S_WB;
        done_d     = 1'b1;
        taken_d    = is_taken;
        misalign_d = trap;
        pc_write_d = commit;
        pc_wdata_d = is_taken ? target : '0;
        flush_d    = {FLUSH_W{commit}};
        // x0 is never written; a trapped jump leaves the link register alone
        if (is_jump && (rd_q != '0) && !trap) begin
          reg_wen_d   = 1'b1;
          reg_waddr_d = rd_q;
          reg_wdata_d = link;
        end
      end

      S_WB: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q       <= S_IDLE;
      op_q          <= OP_NONE;
      funct3_q      <= '0;
      off_q         <= '0;
      pc_q          <= '0;
      rd_q          <= '0;
      reg_raddr_1_q <= '0;
      reg_raddr_2_q <= '0;
      reg_ren_1_q   <= 1'b0;
      reg_ren_2_q   <= 1'b0;
      reg_waddr_q   <= '0;
      reg_wen_q     <= 1'b0;
      reg_wdata_q   <= '0;
      pc_write_q    <= 1'b0;
      pc_wdata_q    <= '0;
      flush_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      taken_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      pc_q          <= pc_d;
      rd_q          <= rd_d;
      reg_raddr_1_q <= reg_raddr_1_d;
      reg_raddr_2_q <= reg_raddr_2_d;
      reg_ren_1_q   <= reg_ren_1_d;
      reg_ren_2_q   <= reg_ren_2_d;
      reg_waddr_q   <= reg_waddr_d;
      reg_wen_q     <= reg_wen_d;
      reg_wdata_q   <= reg_wdata_d;
      pc_write_q    <= pc_write_d;
      pc_wdata_q    <= pc_wdata_d;
      flush_q       <= flush_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      taken_q       <= taken_d;
    end
  end

`ifdef EXU_BRANCH_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign misalign = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_d;
  assign misalign        = 1'b0;
`endif

  assign reg_raddr_1 = reg_raddr_1_q;
  assign reg_raddr_2 = reg_raddr_2_q;
  assign reg_ren_1   = reg_ren_1_q;
  assign reg_ren_2   = reg_ren_2_q;
  assign reg_waddr   = reg_waddr_q;
  assign reg_wen     = reg_wen_q;
  assign reg_wdata   = reg_wdata_q;
  assign pc_write    = pc_write_q;
  assign pc_wdata    = pc_wdata_q;
  assign flush       = flush_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign taken       = taken_q;

endmodule
`default_nettype wire

// File: doc/exu_branch_jump_swc.md
Name: exu_branch_jump_swc

Overview:
- Parametrised successor to the single-purpose jump execution unit in the switch-core MCU.
- Executes JAL, JALR and all six RV32I conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) under its own sequencing FSM with a start/done handshake, replacing external cycle_cnt slotting.
- Reads rs1/rs2 through two register-file read ports, writes the link register, redirects the PC and flushes the front end.

Parameters:
- XLEN, 32, datapath width (PC, register data, targets).
- REG_AW, 5, register address width.
- FLUSH_W, 2, flush vector width; all bits driven together.
- LINK_INC, 4, increment added to pc to form the link value.

Ports:
- hclk  in  1  clock
- hrstn  in  1  asynchronous active-low reset
- start  in  1  launch request; sampled only in IDLE
- dec_jal, dec_jalr, dec_branch  in  1 each  op select; priority jal > jalr > branch
- dec_funct3  in  3  branch condition
- dec_imm_type_i  in  12  JALR offset, sign-extended
- dec_imm_type_j  in  21  JAL offset, sign-extended
- dec_imm_type_b  in  13  branch offset, sign-extended
- dec_rd, dec_rs1, dec_rs2  in  REG_AW  register indices
- pc  in  XLEN  PC of the instruction
- reg_raddr_1, reg_raddr_2  out  REG_AW  read addresses
- reg_ren_1, reg_ren_2  out  1  read enables
- reg_rdata_1, reg_rdata_2  in  XLEN  read data, valid the cycle after ren
- reg_waddr  out  REG_AW  link write address
- reg_wen  out  1  link write enable
- reg_wdata  out  XLEN  link value
- pc_write  out  1  PC redirect strobe
- pc_wdata  out  XLEN  redirect target
- flush  out  FLUSH_W  front-end flush
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- taken  out  1  valid with done; 1 = redirect happened
- misalign  out  1  valid with done; target misaligned (see option)

Behaviour:
- Reset values: all outputs 0, FSM = IDLE. Reset is asynchronous and clears the FSM mid-operation; there are no partial writes after reset deasserts.
- All outputs are registered.
- Inputs (op, funct3, imms, rd/rs, pc) are latched on the IDLE cycle that samples start=1. They are ignored afterwards.
- FSM states: IDLE, RD, EX, WB.
- IDLE → RD when start and (jalr or branch).
- IDLE → EX when start and jal.
- IDLE → WB when start and no op set. This is a no-op completion: done=1, taken=0, no writes.
- RD: one cycle.
  - reg_ren_1=1, reg_raddr_1=rs1.
  - reg_ren_2=1, reg_raddr_2=rs2 for branches only; reg_ren_2=0 for JALR.
- EX: samples rdata and computes target, taken and link = pc+LINK_INC (XLEN wrap-around).
  - JAL: target = pc + sext(imm_j).
  - JALR: target = (rs1 + sext(imm_i)) & ~1. When rd==rs1, the pre-write rs1 value is used.
  - Branch: target = pc + sext(imm_b).
  - funct3 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
  - funct3 010/011 is never taken: no writes, done pulses.
- WB: exactly one cycle, then always returns to IDLE.
  - done=1.
  - When taken: pc_write=1, pc_wdata=target, flush=all ones.
  - Jumps: reg_wen=1, reg_waddr=rd, reg_wdata=link, unless rd==0, in which case reg_wen=0.
  - Branches never write rd.
- Latency from start to done: JAL 2 cycles; JALR and branch 3 cycles.
- start while busy is ignored; it is not queued. A new start is accepted the cycle after done, because the FSM is back in IDLE.
- All strobes (pc_write, reg_wen, flush, ren) are 0 outside their stated state.

Optional Feature:
- Macro EXU_BRANCH_MISALIGN_TRAP_EN.
- Defined: a taken target with target[1:0]!=0 suppresses pc_write, flush and reg_wen, and raises misalign=1 with done. taken still reports the condition result.
- Undefined: misalign is tied 0 and the redirect proceeds with the computed target as is.

Test Plan:
- JAL, pc=0x100, imm_j=0x20, rd=1, start → done at cycle 2; pc_wdata=0x120, flush=2'b11, reg_wen=1, waddr=1, wdata=0x104, taken=1.
- JALR, rs1 data=0x2003, imm_i=0x004, rd=5 → ren_1 in RD; pc_wdata=0x2006 (bit0 cleared); wdata=pc+4; done at cycle 3.
- BLT, rs1=0xFFFFFFFF, rs2=1 → taken, no reg_wen. BLTU with the same operands → taken=0, pc_write=0, flush=0, done=1.
- JAL with rd=0, then a second start asserted while busy → reg_wen stays 0, second start ignored, single done pulse.
- Reset asserted in EX of a taken BEQ → all outputs 0 immediately, no pc_write after release; next start runs normally.
- With the macro defined: JAL, pc=0x100, imm_j=0x2 → misalign=1, pc_write=0, reg_wen=0. Without the macro → pc_wdata=0x102, misalign=0.
